// File: rtl/rf_wb_if.sv
// rf_wb_if: bundle of every signal between the register-file writeback arbiter
// and its neighbours (pipeline writeback, long-latency unit, issue stage, RF).
//
// Signal groups:
//   req0_*           in-order pipeline writeback (valid/rd/data in, ready out)
//   req1_*           long-latency unit writeback (valid/rd/data in, ready out)
//   sb_set, sb_set_rd  issue stage marks a long-op destination as pending
//   rs1, rs2 / rs1_busy, rs2_busy  issue-stage hazard query and answer
//   rf_we, rf_waddr, rf_wdata      the single register-file write port
//
// Modports:
//   master  the surrounding system (drives requests/queries, sees grants/RF port)
//   slave   the arbiter itself
interface rf_wb_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          req0_valid;
   logic [AW-1:0] req0_rd;
   logic [DW-1:0] req0_data;
   logic          req0_ready;

   logic          req1_valid;
   logic [AW-1:0] req1_rd;
   logic [DW-1:0] req1_data;
   logic          req1_ready;

   logic          sb_set;
   logic [AW-1:0] sb_set_rd;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic          rs1_busy;
   logic          rs2_busy;

   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   modport master (
      output req0_valid, req0_rd, req0_data,
      input  req0_ready,
      output req1_valid, req1_rd, req1_data,
      input  req1_ready,
      output sb_set, sb_set_rd, rs1, rs2,
      input  rs1_busy, rs2_busy,
      input  rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      output req0_ready,
      input  req1_valid, req1_rd, req1_data,
      output req1_ready,
      input  sb_set, sb_set_rd, rs1, rs2,
      output rs1_busy, rs2_busy,
      output rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: owner of the single register-file write port.
//
// Arbitrates between the in-order pipeline writeback (req0) and the
// long-latency unit writeback (req1). req0 normally wins ties; after req1 has
// been blocked for STARVE_MAX consecutive cycles it wins one tie. The chosen
// write is registered for one cycle before reaching the RF; writes to r0 are
// accepted but never drive rf_we. A pending-write scoreboard (one bit per
// register) lets the issue stage stall on RAW hazards against long ops.
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous, active-low reset
//   bus    rf_wb_if.slave - request/grant handshakes, scoreboard set/query,
//          and the registered RF write port (rf_we/rf_waddr/rf_wdata)
module rf_wb_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   rf_wb_if.slave  bus
);

   localparam int NREG = 1 << AW;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);

   localparam logic [0:0] PRIO0  = 1'b0;
   localparam logic [0:0] FORCE1 = 1'b1;

   logic [0:0]      state, state_nxt;
   logic [3:0]      starve_cnt, starve_nxt;
   logic [NREG-1:0] sb, sb_nxt;
   logic            grant0, grant1;
   logic            both_valid;

   logic          rf_we_q;
   logic [AW-1:0] rf_waddr_q;
   logic [DW-1:0] rf_wdata_q;

   assign both_valid = bus.req0_valid && bus.req1_valid;

   // Grant: a lone request always wins; on a tie the state decides.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (both_valid) begin
         if (state == FORCE1) grant1 = 1'b1;
         else                 grant0 = 1'b1;
      end else if (bus.req0_valid) begin
         grant0 = 1'b1;
      end else if (bus.req1_valid) begin
         grant1 = 1'b1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;

   // FORCE1 lasts a single cycle at most; it is entered on the tie cycle in
   // which req1 completes its STARVE_MAX-th consecutive blocked cycle.
   always_comb begin
      state_nxt = PRIO0;
      if (state == PRIO0 && both_valid && starve_cnt >= STARVE_LIM)
         state_nxt = FORCE1;
   end

   // Consecutive-blocked counter for req1, saturating at its maximum.
   always_comb begin
      starve_nxt = 4'd0;
      if (bus.req1_valid && !grant1)
         starve_nxt = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
   end

   // Scoreboard update: the accepted long op clears its bit, a new dispatch
   // sets its bit afterwards so a same-register set wins. r0 is never pending.
   always_comb begin
      sb_nxt = sb;
      if (grant1)
         sb_nxt[bus.req1_rd] = 1'b0;
      if (bus.sb_set && bus.sb_set_rd != '0)
         sb_nxt[bus.sb_set_rd] = 1'b1;
      sb_nxt[0] = 1'b0;
   end

   // Arbitration state and scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= PRIO0;
         starve_cnt <= 4'd0;
         sb         <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         sb         <= sb_nxt;
      end
   end

   // Registered RF write port. An r0 grant is a no-op write: rf_we stays low
   // and the address/data registers keep their previous contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else if (grant0 && bus.req0_rd != '0) begin
         rf_we_q    <= 1'b1;
         rf_waddr_q <= bus.req0_rd;
         rf_wdata_q <= bus.req0_data;
      end else if (grant1 && bus.req1_rd != '0) begin
         rf_we_q    <= 1'b1;
         rf_waddr_q <= bus.req1_rd;
         rf_wdata_q <= bus.req1_data;
      end else begin
         rf_we_q    <= 1'b0;
      end
   end

   assign bus.rf_we    = rf_we_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

   assign bus.rs1_busy = sb[bus.rs1];
   assign bus.rs2_busy = sb[bus.rs2];

endmodule
